inst_fetch_buffer: RTL and testbench

Instruction buffer and pre-decoder between the fetch unit and the decode/immediate-generation stage of the RISC-V FP core. It accepts 32-bit instructions with their PCs over a valid/ready handshake and stores them in a DEPTH-entry FIFO. For each instruction it classifies the opcode into the 3-bit immediate-format code consumed by the immediate generator, so decode receives instruction, PC, `imm_op` and an illegal flag together from registered storage.

---
 rtl/inst_fetch_buffer_if.sv | 24 ++
 rtl/inst_fetch_buffer.sv | 106 ++++++++++
 tb/tb_inst_fetch_buffer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_buffer_if.sv
// Fetch-side and decode-side handshake bundle for inst_fetch_buffer.
interface inst_fetch_buffer_if;
  logic        flush_i;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_inst_i;
  logic [31:0] fetch_pc_i;
  logic        dec_valid_o;
  logic        dec_ready_i;
  logic [31:0] dec_inst_o;
  logic [31:0] dec_pc_o;
  logic [2:0]  dec_imm_op_o;
  logic        dec_illegal_o;

  modport slave (
    input  flush_i, fetch_valid_i, fetch_inst_i, fetch_pc_i, dec_ready_i,
    output fetch_ready_o, dec_valid_o, dec_inst_o, dec_pc_o, dec_imm_op_o, dec_illegal_o
  );

  modport master (
    output flush_i, fetch_valid_i, fetch_inst_i, fetch_pc_i, dec_ready_i,
    input  fetch_ready_o, dec_valid_o, dec_inst_o, dec_pc_o, dec_imm_op_o, dec_illegal_o
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction FIFO with opcode pre-decode; head visible one cycle after push (no bypass).
// fetch_ready_o depends on occupancy only, so a full buffer stalls fetch one cycle even while popping.
module inst_fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  inst_fetch_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] inst_q    [DEPTH];
  logic [31:0] pc_q      [DEPTH];
  logic [2:0]  imm_op_q  [DEPTH];
  logic        illegal_q [DEPTH];

  logic       push, pop;
  logic [2:0] pd_imm_op;
  logic       pd_illegal;

  assign bus.fetch_ready_o = (count_q != FULL);
  assign bus.dec_valid_o   = (count_q != '0);
  assign push = bus.fetch_valid_i && bus.fetch_ready_o && !bus.flush_i;
  assign pop  = bus.dec_valid_o && bus.dec_ready_i && !bus.flush_i;

  // Compressed (16-bit) encodings fall through as illegal along with unknown opcodes.
  always_comb begin
    pd_imm_op  = 3'b111;
    pd_illegal = 1'b1;
    if (bus.fetch_inst_i[1:0] == 2'b11) begin
      pd_illegal = 1'b0;
      case (bus.fetch_inst_i[6:0])
        7'b0000011, 7'b0000111, 7'b0010011,
        7'b1100111, 7'b1110011, 7'b0001111: pd_imm_op = 3'b000;
        7'b0100011, 7'b0100111:             pd_imm_op = 3'b001;
        7'b1100011:                         pd_imm_op = 3'b010;
        7'b0110111, 7'b0010111:             pd_imm_op = 3'b011;
        7'b1101111:                         pd_imm_op = 3'b100;
        7'b0110011, 7'b1000011, 7'b1000111,
        7'b1001011, 7'b1001111:             pd_imm_op = 3'b101;
        7'b1010011:                         pd_imm_op = 3'b110;
        default: begin
          pd_imm_op  = 3'b111;
          pd_illegal = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      inst_q[wr_ptr_q]    <= bus.fetch_inst_i;
      pc_q[wr_ptr_q]      <= bus.fetch_pc_i;
      imm_op_q[wr_ptr_q]  <= pd_imm_op;
      illegal_q[wr_ptr_q] <= pd_illegal;
    end
  end

  always_comb begin
    bus.dec_inst_o    = 32'h0000_0013;
    bus.dec_pc_o      = '0;
    bus.dec_imm_op_o  = 3'b000;
    bus.dec_illegal_o = 1'b0;
    if (count_q != '0) begin
      bus.dec_inst_o    = inst_q[rd_ptr_q];
      bus.dec_pc_o      = pc_q[rd_ptr_q];
      bus.dec_imm_op_o  = imm_op_q[rd_ptr_q];
      bus.dec_illegal_o = illegal_q[rd_ptr_q];
    end
  end
endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Directed bench for inst_fetch_buffer (DEPTH=4); inputs change and outputs are sampled on the falling edge.
module tb_inst_fetch_buffer;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  inst_fetch_buffer_if bus ();

  inst_fetch_buffer #(.DEPTH(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [31:0] pc);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_inst_i  = inst;
    bus.fetch_pc_i    = pc;
    cyc();
    bus.fetch_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush_i = 1'b0; bus.fetch_valid_i = 1'b0; bus.fetch_inst_i = '0;
    bus.fetch_pc_i = '0; bus.dec_ready_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", bus.fetch_ready_o); end
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", bus.dec_valid_o); end
    n_cmp++; if (bus.dec_inst_o !== 32'h13) begin n_err++; $display("FAIL rst_inst got %h want 00000013", bus.dec_inst_o); end
    n_cmp++; if (bus.dec_pc_o !== 32'h0) begin n_err++; $display("FAIL rst_pc got %h want 0", bus.dec_pc_o); end
    n_cmp++; if (bus.dec_imm_op_o !== 3'b000) begin n_err++; $display("FAIL rst_imm got %b want 000", bus.dec_imm_op_o); end
    n_cmp++; if (bus.dec_illegal_o !== 1'b0) begin n_err++; $display("FAIL rst_ill got %b want 0", bus.dec_illegal_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bus.dec_ready_i   = 1'b1;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_inst_i  = 32'h0050_0093;
    bus.fetch_pc_i    = 32'h100;
    #1;
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL single_nobypass got %b want 0", bus.dec_valid_o); end
    @(negedge clk);
    bus.fetch_valid_i = 1'b0;
    n_cmp++; if (bus.dec_valid_o !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", bus.dec_valid_o); end
    n_cmp++; if (bus.dec_inst_o !== 32'h0050_0093) begin n_err++; $display("FAIL single_inst got %h want 00500093", bus.dec_inst_o); end
    n_cmp++; if (bus.dec_pc_o !== 32'h100) begin n_err++; $display("FAIL single_pc got %h want 100", bus.dec_pc_o); end
    n_cmp++; if (bus.dec_imm_op_o !== 3'b000) begin n_err++; $display("FAIL single_imm got %b want 000", bus.dec_imm_op_o); end
    n_cmp++; if (bus.dec_illegal_o !== 1'b0) begin n_err++; $display("FAIL single_ill got %b want 0", bus.dec_illegal_o); end
    cyc();
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL single_drained got %b want 0", bus.dec_valid_o); end
    n_cmp++; if (bus.dec_inst_o !== 32'h13) begin n_err++; $display("FAIL single_empty_inst got %h want 00000013", bus.dec_inst_o); end
    bus.dec_ready_i = 1'b0;
  endtask

  task automatic test_fill_hold();
    logic [31:0] ins [5];
    for (int i = 0; i < 5; i++) ins[i] = 32'h00A0_0093 + (32'(i) << 20);
    bus.dec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL fill_ready%0d got %b want 1", i, bus.fetch_ready_o); end
      push_one(ins[i], 32'h200 + 32'(4 * i));
    end
    bus.fetch_valid_i = 1'b1;
    bus.fetch_inst_i  = ins[4];
    bus.fetch_pc_i    = 32'h210;
    n_cmp++; if (bus.fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_full got %b want 0", bus.fetch_ready_o); end
    cyc();
    n_cmp++; if (bus.fetch_ready_o !== 1'b0) begin n_err++; $display("FAIL fill_stall got %b want 0", bus.fetch_ready_o); end
    n_cmp++; if (bus.dec_inst_o !== ins[0]) begin n_err++; $display("FAIL fill_hold got %h want %h", bus.dec_inst_o, ins[0]); end
    n_cmp++; if (bus.dec_pc_o !== 32'h200) begin n_err++; $display("FAIL fill_hold_pc got %h want 200", bus.dec_pc_o); end
    bus.dec_ready_i = 1'b1;
    cyc();
    for (int k = 1; k < 5; k++) begin
      n_cmp++; if (bus.dec_valid_o !== 1'b1) begin n_err++; $display("FAIL drain_valid%0d got %b want 1", k, bus.dec_valid_o); end
      n_cmp++; if (bus.dec_inst_o !== ins[k]) begin n_err++; $display("FAIL drain_inst%0d got %h want %h", k, bus.dec_inst_o, ins[k]); end
      n_cmp++; if (bus.dec_pc_o !== 32'h200 + 32'(4 * k)) begin n_err++; $display("FAIL drain_pc%0d got %h want %h", k, bus.dec_pc_o, 32'h200 + 32'(4 * k)); end
      if (k == 1) begin
        n_cmp++; if (bus.fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL drain_ready got %b want 1", bus.fetch_ready_o); end
      end
      cyc();
      bus.fetch_valid_i = 1'b0;
    end
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty got %b want 0", bus.dec_valid_o); end
    n_cmp++; if (bus.fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL drain_ready_end got %b want 1", bus.fetch_ready_o); end
    bus.dec_ready_i = 1'b0;
  endtask

  task automatic test_format();
    logic [31:0] ins [10] = '{32'h00112623, 32'h00208463, 32'h000012B7, 32'h008000EF,
                              32'h002081B3, 32'h00107053, 32'h00107043, 32'h0FF0000F,
                              32'h00000297, 32'h0000A007};
    logic [2:0]  exp [10] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b101,
                              3'b000, 3'b011, 3'b000};
    bus.dec_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_one(ins[i], 32'h300 + 32'(4 * i));
      n_cmp++; if (bus.dec_imm_op_o !== exp[i]) begin n_err++; $display("FAIL fmt_imm%0d got %b want %b", i, bus.dec_imm_op_o, exp[i]); end
      n_cmp++; if (bus.dec_illegal_o !== 1'b0) begin n_err++; $display("FAIL fmt_ill%0d got %b want 0", i, bus.dec_illegal_o); end
      n_cmp++; if (bus.dec_inst_o !== ins[i]) begin n_err++; $display("FAIL fmt_inst%0d got %h want %h", i, bus.dec_inst_o, ins[i]); end
      cyc();
    end
    bus.dec_ready_i = 1'b0;
  endtask

  task automatic test_illegal();
    push_one(32'h0000007F, 32'h400);
    push_one(32'h00004501, 32'h404);
    n_cmp++; if (bus.dec_inst_o !== 32'h0000007F) begin n_err++; $display("FAIL ill0_inst got %h want 0000007f", bus.dec_inst_o); end
    n_cmp++; if (bus.dec_illegal_o !== 1'b1) begin n_err++; $display("FAIL ill0_flag got %b want 1", bus.dec_illegal_o); end
    n_cmp++; if (bus.dec_imm_op_o !== 3'b111) begin n_err++; $display("FAIL ill0_imm got %b want 111", bus.dec_imm_op_o); end
    bus.dec_ready_i = 1'b1;
    cyc();
    n_cmp++; if (bus.dec_inst_o !== 32'h00004501) begin n_err++; $display("FAIL ill1_inst got %h want 00004501", bus.dec_inst_o); end
    n_cmp++; if (bus.dec_pc_o !== 32'h404) begin n_err++; $display("FAIL ill1_pc got %h want 404", bus.dec_pc_o); end
    n_cmp++; if (bus.dec_illegal_o !== 1'b1) begin n_err++; $display("FAIL ill1_flag got %b want 1", bus.dec_illegal_o); end
    n_cmp++; if (bus.dec_imm_op_o !== 3'b111) begin n_err++; $display("FAIL ill1_imm got %b want 111", bus.dec_imm_op_o); end
    cyc();
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL ill_empty got %b want 0", bus.dec_valid_o); end
    bus.dec_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) push_one(32'h0010_0013 + (32'(i) << 20), 32'h500 + 32'(4 * i));
    bus.flush_i       = 1'b1;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_inst_i  = 32'h0ABC_0093;
    bus.fetch_pc_i    = 32'h50C;
    bus.dec_ready_i   = 1'b1;
    cyc();
    bus.flush_i       = 1'b0;
    bus.fetch_valid_i = 1'b0;
    bus.dec_ready_i   = 1'b0;
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_valid got %b want 0", bus.dec_valid_o); end
    n_cmp++; if (bus.fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready got %b want 1", bus.fetch_ready_o); end
    n_cmp++; if (bus.dec_inst_o !== 32'h13) begin n_err++; $display("FAIL flush_inst got %h want 00000013", bus.dec_inst_o); end
    push_one(32'h0123_0113, 32'h600);
    n_cmp++; if (bus.dec_inst_o !== 32'h0123_0113) begin n_err++; $display("FAIL flush_next_inst got %h want 01230113", bus.dec_inst_o); end
    n_cmp++; if (bus.dec_pc_o !== 32'h600) begin n_err++; $display("FAIL flush_next_pc got %h want 600", bus.dec_pc_o); end
    bus.dec_ready_i = 1'b1;
    cyc();
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_after got %b want 0", bus.dec_valid_o); end
    bus.dec_ready_i = 1'b0;
  endtask

  task automatic test_stream();
    logic [31:0] q_inst [$];
    logic [31:0] q_pc [$];
    int sent = 0;
    int got  = 0;
    int cnt  = 0;
    logic do_push, do_pop;
    for (int c = 0; c < 400 && got < 20; c++) begin
      bus.dec_ready_i   = 1'($urandom_range(0, 1));
      bus.fetch_valid_i = (sent < 20);
      bus.fetch_inst_i  = {12'(sent + 16), 20'h00193};
      bus.fetch_pc_i    = 32'h1000 + 32'(4 * sent);
      n_cmp++; if (bus.fetch_ready_o !== (cnt != 4)) begin n_err++; $display("FAIL stream_ready c%0d got %b want %b", c, bus.fetch_ready_o, cnt != 4); end
      n_cmp++; if (bus.dec_valid_o !== (cnt != 0)) begin n_err++; $display("FAIL stream_valid c%0d got %b want %b", c, bus.dec_valid_o, cnt != 0); end
      if (cnt != 0) begin
        n_cmp++; if (bus.dec_inst_o !== q_inst[0]) begin n_err++; $display("FAIL stream_inst c%0d got %h want %h", c, bus.dec_inst_o, q_inst[0]); end
        n_cmp++; if (bus.dec_pc_o !== q_pc[0]) begin n_err++; $display("FAIL stream_pc c%0d got %h want %h", c, bus.dec_pc_o, q_pc[0]); end
      end
      do_push = bus.fetch_valid_i && (cnt != 4);
      do_pop  = (cnt != 0) && bus.dec_ready_i;
      if (do_pop) begin
        void'(q_inst.pop_front());
        void'(q_pc.pop_front());
        got++;
        cnt--;
      end
      if (do_push) begin
        q_inst.push_back(bus.fetch_inst_i);
        q_pc.push_back(bus.fetch_pc_i);
        sent++;
        cnt++;
      end
      cyc();
    end
    bus.fetch_valid_i = 1'b0;
    bus.dec_ready_i   = 1'b0;
    n_cmp++; if (got !== 20) begin n_err++; $display("FAIL stream_count got %0d want 20", got); end
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_empty got %b want 0", bus.dec_valid_o); end
  endtask

  task automatic test_reset_mid();
    push_one(32'h0010_0093, 32'h700);
    push_one(32'h0020_0093, 32'h704);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", bus.dec_valid_o); end
    n_cmp++; if (bus.fetch_ready_o !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %b want 1", bus.fetch_ready_o); end
    n_cmp++; if (bus.dec_inst_o !== 32'h13) begin n_err++; $display("FAIL rstmid_inst got %h want 00000013", bus.dec_inst_o); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    n_cmp++; if (bus.dec_valid_o !== 1'b0) begin n_err++; $display("FAIL rstmid_after got %b want 0", bus.dec_valid_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_fill_hold();
    test_format();
    test_illegal();
    test_flush();
    test_stream();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
